// File: rtl/bp_retire_update.sv
// Retire-side branch update: pops the branch ordering buffer head, trains the local/global/choice
// PHTs and local history table, and issues a one-cycle mispredict recovery pulse.
module bp_retire_update #(
    parameter int CTR_W   = 2,
    parameter int LHT_IDX = 10
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               br_vld_rt_i,
    input  logic               br_cond_rt_i,
    input  logic               br_taken_rt_i,
    input  logic [63:0]        br_target_rt_i,
    input  logic               br_mispred_rt_i,
    output logic               rt_ready_o,
    input  logic               bob_valid_i,
    input  logic [63:0]        bob_brpc_i,
    input  logic               bob_brdir_i,
    input  logic               bob_chwe_i,
    input  logic               bob_chbrdir_i,
    input  logic [9:0]         bob_bht_i,
    input  logic [11:0]        bob_bhr_i,
    input  logic [3:0]         bob_rasptr_i,
    output logic               bob_re_o,
    output logic               pht_re_o,
    output logic [9:0]         lpht_idx_o,
    output logic [11:0]        gpht_idx_o,
    input  logic [CTR_W-1:0]   lpht_rdata_i,
    input  logic [CTR_W-1:0]   gpht_rdata_i,
    input  logic [CTR_W-1:0]   cpht_rdata_i,
    output logic               lpht_we_o,
    output logic               gpht_we_o,
    output logic               cpht_we_o,
    output logic [CTR_W-1:0]   lpht_wdata_o,
    output logic [CTR_W-1:0]   gpht_wdata_o,
    output logic [CTR_W-1:0]   cpht_wdata_o,
    output logic               lht_we_o,
    output logic [LHT_IDX-1:0] lht_idx_o,
    output logic [9:0]         lht_wdata_o,
    output logic               recover_o,
    output logic [63:0]        recover_pc_o,
    output logic [11:0]        recover_bhr_o,
    output logic [3:0]         recover_rasptr_o,
    output logic               underflow_o
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    state_t state, state_nxt;

    logic               accept;
    logic               mispredict;
    logic [LHT_IDX-1:0] lht_idx_q;
    logic [9:0]         bht_q;
    logic [11:0]        bhr_q;
    logic               taken_q;
    logic               chwe_q;
    logic               chbrdir_q;

    function automatic logic [CTR_W-1:0] sat_step(input logic [CTR_W-1:0] ctr, input logic up);
        if (up)
            return (ctr == CTR_MAX) ? ctr : ctr + 1'b1;
        else
            return (ctr == '0) ? ctr : ctr - 1'b1;
    endfunction

    assign rt_ready_o = (state == IDLE);
    assign accept     = br_vld_rt_i & rt_ready_o & bob_valid_i;
    assign bob_re_o   = accept;
    assign mispredict = br_cond_rt_i ? (br_taken_rt_i != bob_brdir_i) : br_mispred_rt_i;

    // NOTE: all sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation behaviour.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && br_cond_rt_i) state_nxt = READ;
            READ:    state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush)
            state_nxt = IDLE;
    end

    // Only the fields the READ/WRITE phases still need are kept; recovery is resolved at accept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lht_idx_q <= '0;
            bht_q     <= '0;
            bhr_q     <= '0;
            taken_q   <= 1'b0;
            chwe_q    <= 1'b0;
            chbrdir_q <= 1'b0;
        end else if (accept) begin
            lht_idx_q <= bob_brpc_i[LHT_IDX+1:2];
            bht_q     <= bob_bht_i;
            bhr_q     <= bob_bhr_i;
            taken_q   <= br_taken_rt_i;
            chwe_q    <= bob_chwe_i;
            chbrdir_q <= bob_chbrdir_i;
        end
    end

    // Recovery payload only updates on a pulse so consumers may sample it lazily.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            recover_o        <= 1'b0;
            recover_pc_o     <= '0;
            recover_bhr_o    <= '0;
            recover_rasptr_o <= '0;
        end else begin
            recover_o <= accept & mispredict & ~flush;
            if (accept && mispredict && !flush) begin
                recover_rasptr_o <= bob_rasptr_i;
                if (br_cond_rt_i) begin
                    recover_bhr_o <= {bob_bhr_i[10:0], br_taken_rt_i};
                    recover_pc_o  <= br_taken_rt_i ? br_target_rt_i : bob_brpc_i + 64'd4;
                end else begin
                    recover_bhr_o <= bob_bhr_i;
                    recover_pc_o  <= br_target_rt_i;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            underflow_o <= 1'b0;
        else if (br_vld_rt_i && !bob_valid_i)
            underflow_o <= 1'b1;
    end

    // NOTE: every output gets a default before the case so no path leaves a latch behind.
    always_comb begin
        pht_re_o     = 1'b0;
        lpht_idx_o   = '0;
        gpht_idx_o   = '0;
        lht_we_o     = 1'b0;
        lht_idx_o    = '0;
        lht_wdata_o  = '0;
        lpht_we_o    = 1'b0;
        gpht_we_o    = 1'b0;
        cpht_we_o    = 1'b0;
        lpht_wdata_o = '0;
        gpht_wdata_o = '0;
        cpht_wdata_o = '0;
        case (state)
            READ: begin
                pht_re_o    = 1'b1;
                lpht_idx_o  = bht_q;
                gpht_idx_o  = bhr_q;
                lht_we_o    = ~flush;
                lht_idx_o   = lht_idx_q;
                lht_wdata_o = {bht_q[8:0], taken_q};
            end
            WRITE: begin
                lpht_we_o    = ~flush;
                gpht_we_o    = ~flush;
                cpht_we_o    = chwe_q & ~flush;
                lpht_wdata_o = sat_step(lpht_rdata_i, taken_q);
                gpht_wdata_o = sat_step(gpht_rdata_i, taken_q);
                cpht_wdata_o = sat_step(cpht_rdata_i, chbrdir_q);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bp_retire_update.sv
// Self-checking bench for bp_retire_update: directed vector table, corner sequences and
// randomized transactions checked against a per-branch behavioural model.
module tb_bp_retire_update;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        br_vld_rt_i, br_cond_rt_i, br_taken_rt_i, br_mispred_rt_i;
    logic [63:0] br_target_rt_i;
    logic        rt_ready_o;
    logic        bob_valid_i, bob_brdir_i, bob_chwe_i, bob_chbrdir_i;
    logic [63:0] bob_brpc_i;
    logic [9:0]  bob_bht_i;
    logic [11:0] bob_bhr_i;
    logic [3:0]  bob_rasptr_i;
    logic        bob_re_o, pht_re_o;
    logic [9:0]  lpht_idx_o;
    logic [11:0] gpht_idx_o;
    logic [1:0]  lpht_rdata_i, gpht_rdata_i, cpht_rdata_i;
    logic        lpht_we_o, gpht_we_o, cpht_we_o;
    logic [1:0]  lpht_wdata_o, gpht_wdata_o, cpht_wdata_o;
    logic        lht_we_o;
    logic [9:0]  lht_idx_o, lht_wdata_o;
    logic        recover_o;
    logic [63:0] recover_pc_o;
    logic [11:0] recover_bhr_o;
    logic [3:0]  recover_rasptr_o;
    logic        underflow_o;

    int n_checks = 0;
    int n_errors = 0;
    bit exp_uf   = 1'b0;

    always #5 clock = ~clock;

    bp_retire_update #(.CTR_W(2), .LHT_IDX(10)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .br_vld_rt_i(br_vld_rt_i), .br_cond_rt_i(br_cond_rt_i), .br_taken_rt_i(br_taken_rt_i),
        .br_target_rt_i(br_target_rt_i), .br_mispred_rt_i(br_mispred_rt_i), .rt_ready_o(rt_ready_o),
        .bob_valid_i(bob_valid_i), .bob_brpc_i(bob_brpc_i), .bob_brdir_i(bob_brdir_i),
        .bob_chwe_i(bob_chwe_i), .bob_chbrdir_i(bob_chbrdir_i), .bob_bht_i(bob_bht_i),
        .bob_bhr_i(bob_bhr_i), .bob_rasptr_i(bob_rasptr_i), .bob_re_o(bob_re_o),
        .pht_re_o(pht_re_o), .lpht_idx_o(lpht_idx_o), .gpht_idx_o(gpht_idx_o),
        .lpht_rdata_i(lpht_rdata_i), .gpht_rdata_i(gpht_rdata_i), .cpht_rdata_i(cpht_rdata_i),
        .lpht_we_o(lpht_we_o), .gpht_we_o(gpht_we_o), .cpht_we_o(cpht_we_o),
        .lpht_wdata_o(lpht_wdata_o), .gpht_wdata_o(gpht_wdata_o), .cpht_wdata_o(cpht_wdata_o),
        .lht_we_o(lht_we_o), .lht_idx_o(lht_idx_o), .lht_wdata_o(lht_wdata_o),
        .recover_o(recover_o), .recover_pc_o(recover_pc_o), .recover_bhr_o(recover_bhr_o),
        .recover_rasptr_o(recover_rasptr_o), .underflow_o(underflow_o)
    );

    typedef struct {
        bit          cond, taken, mispred, brdir, chwe, chbrdir;
        logic [63:0] target, brpc;
        logic [9:0]  bht;
        logic [11:0] bhr;
        logic [3:0]  rasptr;
        logic [1:0]  lrd, grd, crd;
        int          flush_at;   // 0 none, 1 = flush in T+1, 2 = flush in T+2
        bit          exp_rec;
        logic [63:0] exp_pc;
        logic [11:0] exp_rbhr;
        logic [3:0]  exp_ras;
        logic [1:0]  exp_lw, exp_gw, exp_cw;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: counters as plain integers clamped to [0,3].
    function automatic logic [1:0] step(input int ctr, input bit up);
        int n;
        n = up ? ctr + 1 : ctr - 1;
        if (n < 0) n = 0;
        if (n > 3) n = 3;
        return n[1:0];
    endfunction

    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_rec  = v.cond ? (v.taken != v.brdir) : v.mispred;
        r.exp_pc   = (v.cond && !v.taken) ? v.brpc + 64'd4 : v.target;
        r.exp_rbhr = v.cond ? ((v.bhr * 2 + v.taken) % 4096) : v.bhr;
        r.exp_ras  = v.rasptr;
        r.exp_lw   = step(v.lrd, v.taken);
        r.exp_gw   = step(v.grd, v.taken);
        r.exp_cw   = step(v.crd, v.chbrdir);
        return r;
    endfunction

    task automatic drive_entry(input vec_t v);
        br_vld_rt_i = 1'b1;      bob_valid_i     = 1'b1;
        br_cond_rt_i = v.cond;   br_taken_rt_i   = v.taken;
        br_mispred_rt_i = v.mispred; br_target_rt_i = v.target;
        bob_brpc_i = v.brpc;     bob_brdir_i     = v.brdir;
        bob_chwe_i = v.chwe;     bob_chbrdir_i   = v.chbrdir;
        bob_bht_i = v.bht;       bob_bhr_i       = v.bhr;
        bob_rasptr_i = v.rasptr;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        bit f;
        logic [9:0] exp_lht_wd;
        @(negedge clock);
        drive_entry(v);
        flush = 1'b0;
        #1;
        check({tag, ".pop"}, bob_re_o, 1);
        check({tag, ".ready_T"}, rt_ready_o, 1);
        check({tag, ".rec_T"}, recover_o, 0);
        @(posedge clock);
        @(negedge clock);
        br_vld_rt_i = 1'b0; bob_valid_i = 1'b0;
        f = (v.flush_at == 1);
        flush = f;
        #1;
        check({tag, ".pop_T1"}, bob_re_o, 0);
        check({tag, ".rec"}, recover_o, v.exp_rec);
        if (v.exp_rec) begin
            check({tag, ".rec_pc"}, recover_pc_o, v.exp_pc);
            check({tag, ".rec_bhr"}, recover_bhr_o, v.exp_rbhr);
            check({tag, ".rec_ras"}, recover_rasptr_o, v.exp_ras);
        end
        if (v.cond) begin
            exp_lht_wd = {v.bht[8:0], v.taken};
            check({tag, ".pht_re"}, pht_re_o, 1);
            check({tag, ".lpht_idx"}, lpht_idx_o, v.bht);
            check({tag, ".gpht_idx"}, gpht_idx_o, v.bhr);
            check({tag, ".lht_we"}, lht_we_o, !f);
            check({tag, ".lht_idx"}, lht_idx_o, v.brpc[11:2]);
            check({tag, ".lht_wdata"}, lht_wdata_o, exp_lht_wd);
            check({tag, ".ready_T1"}, rt_ready_o, 0);
        end else begin
            check({tag, ".pht_re"}, pht_re_o, 0);
            check({tag, ".lht_we"}, lht_we_o, 0);
            check({tag, ".ready_T1"}, rt_ready_o, 1);
        end
        @(posedge clock);
        if (v.cond) begin
            @(negedge clock);
            f = (v.flush_at == 2);
            flush = f;
            lpht_rdata_i = v.lrd; gpht_rdata_i = v.grd; cpht_rdata_i = v.crd;
            #1;
            check({tag, ".rec_T2"}, recover_o, 0);
            if (v.flush_at == 1) begin
                check({tag, ".ready_T2"}, rt_ready_o, 1);
                check({tag, ".lpht_we"}, lpht_we_o, 0);
                check({tag, ".gpht_we"}, gpht_we_o, 0);
                check({tag, ".cpht_we"}, cpht_we_o, 0);
            end else begin
                check({tag, ".ready_T2"}, rt_ready_o, 0);
                check({tag, ".lpht_we"}, lpht_we_o, !f);
                check({tag, ".gpht_we"}, gpht_we_o, !f);
                check({tag, ".cpht_we"}, cpht_we_o, v.chwe && !f);
                if (!f) begin
                    check({tag, ".lpht_wd"}, lpht_wdata_o, v.exp_lw);
                    check({tag, ".gpht_wd"}, gpht_wdata_o, v.exp_gw);
                end
                if (v.chwe && !f)
                    check({tag, ".cpht_wd"}, cpht_wdata_o, v.exp_cw);
            end
            @(posedge clock);
        end
        @(negedge clock);
        flush = 1'b0;
        #1;
        check({tag, ".ready_end"}, rt_ready_o, 1);
        check({tag, ".rec_end"}, recover_o, 0);
        check({tag, ".we_end"}, {lpht_we_o, gpht_we_o, cpht_we_o, lht_we_o, pht_re_o}, 0);
        check({tag, ".underflow"}, underflow_o, exp_uf);
        @(posedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        reset_n = 1'b0; flush = 1'b0;
        br_vld_rt_i = 0; br_cond_rt_i = 0; br_taken_rt_i = 0; br_mispred_rt_i = 0;
        br_target_rt_i = '0; bob_valid_i = 0; bob_brpc_i = '0; bob_brdir_i = 0;
        bob_chwe_i = 0; bob_chbrdir_i = 0; bob_bht_i = '0; bob_bhr_i = '0; bob_rasptr_i = '0;
        lpht_rdata_i = '0; gpht_rdata_i = '0; cpht_rdata_i = '0;

        //          cond tk mis dir chwe chd target          brpc            bht     bhr      ras  lrd grd crd fl rec pc              rbhr     ras  lw gw cw
        tbl[0] = '{1, 1, 0, 1, 0, 0, 64'h4000,       64'h3000, 10'h155, 12'hABC, 4'd3, 1, 3, 0, 0, 0, 64'h0,        12'h000, 4'd0, 2, 3, 0};
        tbl[1] = '{1, 0, 0, 1, 0, 0, 64'h5000,       64'h1000, 10'h0AA, 12'h801, 4'd5, 0, 0, 0, 0, 1, 64'h1004,     12'h002, 4'd5, 0, 0, 0};
        tbl[2] = '{1, 1, 0, 1, 1, 0, 64'h6000,       64'h2040, 10'h3FF, 12'h123, 4'd1, 3, 2, 2, 0, 0, 64'h0,        12'h000, 4'd0, 3, 3, 1};
        tbl[3] = '{1, 1, 0, 1, 0, 0, 64'h6000,       64'h2040, 10'h3FF, 12'h123, 4'd1, 3, 2, 2, 0, 0, 64'h0,        12'h000, 4'd0, 3, 3, 1};
        tbl[4] = '{0, 1, 1, 0, 0, 0, 64'h2000,       64'h1800, 10'h011, 12'h3C5, 4'd9, 0, 0, 0, 0, 1, 64'h2000,     12'h3C5, 4'd9, 0, 0, 0};
        tbl[5] = '{0, 1, 0, 1, 0, 0, 64'h7000,       64'h1900, 10'h022, 12'h456, 4'd2, 0, 0, 0, 0, 0, 64'h0,        12'h000, 4'd0, 0, 0, 0};
        tbl[6] = '{1, 0, 0, 1, 1, 1, 64'h5000,       64'h1000, 10'h0AA, 12'h801, 4'd5, 2, 2, 2, 1, 1, 64'h1004,     12'h002, 4'd5, 1, 1, 3};
        tbl[7] = '{1, 1, 0, 0, 1, 1, 64'hDEAD_BEE0,  64'h8000, 10'h200, 12'hFFF, 4'hF, 0, 1, 3, 0, 1, 64'hDEAD_BEE0, 12'hFFF, 4'hF, 1, 2, 3};
        tbl[8] = '{1, 0, 0, 0, 1, 1, 64'h9000,       64'hA00C, 10'h133, 12'h777, 4'd7, 2, 2, 1, 2, 0, 64'h0,        12'h000, 4'd0, 1, 1, 2};

        repeat (2) @(negedge clock);
        #1;
        check("reset.ready", rt_ready_o, 1);
        check("reset.strobes", {bob_re_o, pht_re_o, lpht_we_o, gpht_we_o, cpht_we_o, lht_we_o}, 0);
        check("reset.recover", recover_o, 0);
        check("reset.underflow", underflow_o, 0);
        check("reset.idx", {lpht_idx_o, gpht_idx_o, lht_idx_o, lht_wdata_o}, 0);
        check("reset.rec_data", recover_pc_o ^ {recover_bhr_o, recover_rasptr_o}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);

        for (int i = 0; i < 9; i++)
            run_txn(tbl[i], $sformatf("vec%0d", i));

        // Flush in the accept cycle: pop still happens, no recovery, no READ phase.
        v = tbl[1];
        @(negedge clock);
        drive_entry(v);
        flush = 1'b1;
        #1;
        check("flushT.pop", bob_re_o, 1);
        @(posedge clock);
        @(negedge clock);
        br_vld_rt_i = 0; bob_valid_i = 0; flush = 0;
        #1;
        check("flushT.rec", recover_o, 0);
        check("flushT.ready", rt_ready_o, 1);
        check("flushT.pht_re", pht_re_o, 0);
        @(posedge clock);

        // Back-to-back non-conditional branches accepted on consecutive cycles.
        v = tbl[4];
        @(negedge clock);
        drive_entry(v);
        #1;
        check("b2b.pop0", bob_re_o, 1);
        @(posedge clock);
        @(negedge clock);
        v = tbl[5];
        drive_entry(v);
        #1;
        check("b2b.pop1", bob_re_o, 1);
        check("b2b.ready1", rt_ready_o, 1);
        check("b2b.rec0", recover_o, 1);
        check("b2b.rec0_pc", recover_pc_o, 64'h2000);
        @(posedge clock);
        @(negedge clock);
        br_vld_rt_i = 0; bob_valid_i = 0;
        #1;
        check("b2b.rec1", recover_o, 0);
        check("b2b.pc_hold", recover_pc_o, 64'h2000);
        @(posedge clock);

        // Retire with an empty buffer: no pop, sticky underflow.
        @(negedge clock);
        br_vld_rt_i = 1; bob_valid_i = 0;
        #1;
        check("uf.pop", bob_re_o, 0);
        check("uf.ready", rt_ready_o, 1);
        @(posedge clock);
        @(negedge clock);
        br_vld_rt_i = 0;
        exp_uf = 1'b1;
        #1;
        check("uf.set", underflow_o, 1);
        check("uf.ready_after", rt_ready_o, 1);
        run_txn(tbl[0], "uf_sticky");

        // Reset mid-operation: abort in READ, nothing written after release.
        @(negedge clock);
        drive_entry(tbl[2]);
        @(posedge clock);
        @(negedge clock);
        br_vld_rt_i = 0; bob_valid_i = 0;
        reset_n = 1'b0;
        exp_uf = 1'b0;
        #1;
        check("rst.ready", rt_ready_o, 1);
        check("rst.strobes", {pht_re_o, lht_we_o, lpht_we_o, gpht_we_o, cpht_we_o}, 0);
        check("rst.underflow", underflow_o, 0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("rst.we_after", {lpht_we_o, gpht_we_o, cpht_we_o}, 0);
        @(negedge clock);
        #1;
        check("rst.we_after2", {lpht_we_o, gpht_we_o, cpht_we_o, pht_re_o}, 0);
        check("rst.ready_after", rt_ready_o, 1);

        // Randomized transactions against the model.
        for (int i = 0; i < 60; i++) begin
            int r;
            v = tbl[0];
            v.cond    = ($urandom_range(0, 9) < 7);
            v.taken   = $urandom_range(0, 1);
            v.mispred = $urandom_range(0, 1);
            v.brdir   = $urandom_range(0, 1);
            v.chwe    = $urandom_range(0, 1);
            v.chbrdir = $urandom_range(0, 1);
            v.target  = {$urandom, $urandom} & ~64'h3;
            v.brpc    = {$urandom, $urandom} & ~64'h3;
            v.bht     = 10'($urandom);
            v.bhr     = 12'($urandom);
            v.rasptr  = 4'($urandom);
            v.lrd     = 2'($urandom);
            v.grd     = 2'($urandom);
            v.crd     = 2'($urandom);
            r = $urandom_range(0, 9);
            v.flush_at = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            run_txn(model(v), $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bp_retire_update.md
Name: bp_retire_update

Overview:
- Retire-side consumer of the branch ordering buffer: pops the head checkpoint when a branch retires and trains the predictor tables with the actual outcome.
- For a conditional branch it detects a direction mispredict and drives a one-cycle recovery pulse carrying the restored global history, RAS pointer and redirect PC.
- Sits between the retire stage, the buffer head port and the predictor tables: local history table, local PHT, global PHT and choice PHT.
- PHT reads are external with 1-cycle read latency.

Parameters:
- CTR_W, 2, saturating counter width for all PHTs
- LHT_IDX, 10, local history table index width, taken from brpc[LHT_IDX+1:2]

Ports:
- clock  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; synchronous abort to IDLE
- br_vld_rt_i  in  1  retiring branch valid; held until accepted
- br_cond_rt_i  in  1  1 = conditional, 0 = unconditional/indirect
- br_taken_rt_i  in  1  actual direction
- br_target_rt_i  in  64  actual next PC if taken
- br_mispred_rt_i  in  1  mispredict flag for non-conditional branches
- rt_ready_o  out  1  block idle, can accept
- bob_valid_i  in  1  head entry valid
- bob_brpc_i  in  64  head branch PC
- bob_brdir_i  in  1  head predicted direction
- bob_chwe_i  in  1  head choice-update enable
- bob_chbrdir_i  in  1  head choice training direction
- bob_bht_i  in  10  head local history
- bob_bhr_i  in  12  head global history
- bob_rasptr_i  in  4  head RAS pointer
- bob_re_o  out  1  pop head entry
- pht_re_o  out  1  PHT read strobe
- lpht_idx_o  out  10  local PHT index
- gpht_idx_o  out  12  global/choice PHT index
- lpht_rdata_i  in  CTR_W  local PHT read data
- gpht_rdata_i  in  CTR_W  global PHT read data
- cpht_rdata_i  in  CTR_W  choice PHT read data
- lpht_we_o  out  1  local PHT write enable
- gpht_we_o  out  1  global PHT write enable
- cpht_we_o  out  1  choice PHT write enable
- lpht_wdata_o  out  CTR_W  local PHT write data
- gpht_wdata_o  out  CTR_W  global PHT write data
- cpht_wdata_o  out  CTR_W  choice PHT write data
- lht_we_o  out  1  local history write enable
- lht_idx_o  out  LHT_IDX  local history index
- lht_wdata_o  out  10  local history write data
- recover_o  out  1  mispredict recovery pulse
- recover_pc_o  out  64  redirect PC
- recover_bhr_o  out  12  restored global history
- recover_rasptr_o  out  4  restored RAS pointer
- underflow_o  out  1  sticky: retire branch with empty buffer

Behaviour:
Reset:
- State = IDLE; all strobes, recover_o and underflow_o are 0; all index/data outputs are 0; rt_ready_o = 1.

States: IDLE, READ, WRITE.
- rt_ready_o = (state == IDLE).

Accept (cycle T): br_vld_rt_i & rt_ready_o & bob_valid_i.
- bob_re_o = 1, combinationally, in cycle T only.
- Entry and outcome are captured into registers at the end of T.
- Next state:
  - conditional → READ
  - non-conditional → IDLE; no PHT or LHT activity.

Empty buffer:
- br_vld_rt_i & bob_valid_i = 0 → no pop, no accept, underflow_o set to 1 and held until reset.

READ (T+1):
- pht_re_o = 1, lpht_idx_o = bht, gpht_idx_o = bhr.
- lht_we_o = 1, lht_idx_o = brpc[11:2], lht_wdata_o = {bht[8:0], taken}.
- Next state: WRITE.

WRITE (T+2): PHT read data is valid this cycle.
- lpht_we_o = gpht_we_o = 1. Each counter becomes ctr+1 if taken, else ctr-1, saturating at 0 and 2^CTR_W-1.
- cpht_we_o = chwe. The choice counter moves up if chbrdir = 1, else down, with the same saturation.
- Next state: IDLE.

Recovery, registered, 1-cycle pulse at T+1:
- Conditional branch with taken != brdir:
  - recover_o = 1
  - recover_bhr_o = {bhr[10:0], taken}
  - recover_rasptr_o = rasptr
  - recover_pc_o = taken ? target : brpc+4
- Non-conditional branch with br_mispred_rt_i = 1:
  - recover_o = 1, recover_bhr_o = bhr, recover_rasptr_o = rasptr, recover_pc_o = target.
- recover_* data outputs hold their last value when recover_o = 0.

Flush:
- flush = 1 in any cycle → next state IDLE.
- PHT/LHT write strobes are forced to 0 in that cycle; no recover pulse is issued after it.
- A pop that occurs in the same cycle as flush is still driven; the buffer clears itself on flush.

Other rules:
- Reset asserted mid-operation aborts immediately; no partial writes after deassertion.
- Back-to-back branches: the next accept is possible at T+3 for a conditional branch and at T+1 for a non-conditional branch.

Test Plan:
1. Conditional branch: brdir = 1, taken = 1, bht = 10'h155, bhr = 12'hABC, PHT reads lpht = 1, gpht = 3 → pop at T; read at T+1 with idx 155/ABC; write at T+2 with lpht = 2, gpht = 3 (saturated); no recover_o.
2. Conditional mispredict: brdir = 1, taken = 0, brpc = 64'h1000, bhr = 12'h801, rasptr = 5 → recover_o at T+1 with pc = 64'h1004, bhr = 12'h002, rasptr = 5; counters at 0 stay 0.
3. Choice update: chwe = 1, chbrdir = 0, cpht read 2 → cpht_we_o = 1, wdata = 1. Repeat with chwe = 0 → cpht_we_o = 0.
4. Indirect branch: br_cond = 0, mispred = 1, target = 64'h2000 → pop, recover at T+1 with pc 2000; no pht_re_o; rt_ready_o stays 1.
5. br_vld_rt_i with bob_valid_i = 0 → bob_re_o = 0, underflow_o = 1 and sticky; rt_ready_o = 1.
6. flush asserted at T+1 of a conditional mispredict → no lpht/gpht/cpht writes; state is IDLE at T+2; rt_ready_o = 1.
